vram_write_arbiter: RTL and testbench

- Shares the single VRAM write path between NREQ write requesters, e.g. CPU bus bridge, blitter and palette loader.
- Arbitrates round-robin and buffers granted writes in a small FIFO.
- Presents the FIFO head to the memory time-slot controller, which drains one entry per write slot.
- Decouples requester timing from the fixed slot schedule of the VRAM controller.

---
 rtl/vram_write_arbiter.sv | 131 +++++++++++++
 tb/tb_vram_write_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_write_arbiter.sv
// Round-robin arbiter that funnels NREQ VRAM write requesters into a small
// register FIFO. The slot controller drains the FIFO head one entry per write slot.
module vram_write_arbiter #(
    parameter int unsigned AWIDTH = 19,
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned NREQ   = 4,
    parameter int unsigned FDEPTH = 4
) (
    input  logic                     MemClk,
    input  logic                     MemRstN,
    input  logic [NREQ-1:0]          ReqValid,
    input  logic [NREQ*AWIDTH-1:0]   ReqAddr,
    input  logic [NREQ*DWIDTH-1:0]   ReqData,
    output logic [NREQ-1:0]          ReqAck,
    input  logic                     SlotWrStrobe,
    output logic                     WrValid,
    output logic [AWIDTH-1:0]        WrAddr,
    output logic [DWIDTH-1:0]        WrData,
    output logic                     WrTake,
    output logic                     SlotMiss,
    output logic [$clog2(FDEPTH):0]  FifoLevel
);

    localparam int unsigned PW = $clog2(FDEPTH);
    localparam int unsigned RW = $clog2(NREQ);
    localparam int unsigned LW = PW + 1;

    logic [AWIDTH-1:0] addr_mem [FDEPTH];
    logic [DWIDTH-1:0] data_mem [FDEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]     level_q, level_d;
    logic [RW-1:0]     rr_q, rr_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              take_q, miss_q;

    logic [NREQ-1:0]   eligible;
    logic              any_elig;
    logic [RW-1:0]     winner;
    logic              pop, push;
    logic [AWIDTH-1:0] win_addr;
    logic [DWIDTH-1:0] win_data;

    // The requester acked this cycle may still hold valid; mask it so it is not taken twice.
    assign eligible = ReqValid & ~ack_q;
    assign pop      = SlotWrStrobe && WrValid;
    assign push     = any_elig && ((level_q < LW'(FDEPTH)) || pop);
    assign win_addr = ReqAddr[32'(winner) * AWIDTH +: AWIDTH];
    assign win_data = ReqData[32'(winner) * DWIDTH +: DWIDTH];

    // Round-robin scan: first eligible index starting at the RR pointer, wrapping at NREQ.
    always_comb begin
        int idx;
        any_elig = 1'b0;
        winner   = '0;
        idx      = 0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = int'(rr_q) + k;
            if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
            if (!any_elig && eligible[RW'(idx)]) begin
                any_elig = 1'b1;
                winner   = RW'(idx);
            end
        end
    end

    // Next-state for level, RR pointer and ack pulse.
    always_comb begin
        level_d = level_q;
        rr_d    = rr_q;
        ack_d   = '0;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (push) begin
            ack_d[winner] = 1'b1;
            rr_d = (32'(winner) == NREQ - 1) ? '0 : winner + RW'(1);
        end
    end

    // FIFO storage; cleared on reset so the head reads zero while empty after reset.
    always_ff @(posedge MemClk or negedge MemRstN) begin
        if (!MemRstN) begin
            for (int i = 0; i < int'(FDEPTH); i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else if (push) begin
            addr_mem[wr_ptr_q] <= win_addr;
            data_mem[wr_ptr_q] <= win_data;
        end
    end

    // FIFO pointers and occupancy; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge MemClk or negedge MemRstN) begin
        if (!MemRstN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            level_q <= level_d;
        end
    end

    // Arbiter state and registered status pulses.
    always_ff @(posedge MemClk or negedge MemRstN) begin
        if (!MemRstN) begin
            rr_q   <= '0;
            ack_q  <= '0;
            take_q <= 1'b0;
            miss_q <= 1'b0;
        end else begin
            rr_q   <= rr_d;
            ack_q  <= ack_d;
            take_q <= pop;
            miss_q <= SlotWrStrobe && !WrValid;
        end
    end

    assign ReqAck    = ack_q;
    assign WrTake    = take_q;
    assign SlotMiss  = miss_q;
    assign WrValid   = (level_q != '0);
    assign WrAddr    = addr_mem[rd_ptr_q];
    assign WrData    = data_mem[rd_ptr_q];
    assign FifoLevel = level_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Bench for vram_write_arbiter: constant vector table, directed corner sequences,
// and random traffic compared against a queue-based reference model.
module tb_vram_write_arbiter;

    localparam int AW = 19;
    localparam int DW = 8;
    localparam int NR = 4;
    localparam int FD = 4;

    logic              MemClk = 1'b0;
    logic              MemRstN;
    logic [NR-1:0]     ReqValid;
    logic [NR*AW-1:0]  ReqAddr;
    logic [NR*DW-1:0]  ReqData;
    logic [NR-1:0]     ReqAck;
    logic              SlotWrStrobe;
    logic              WrValid;
    logic [AW-1:0]     WrAddr;
    logic [DW-1:0]     WrData;
    logic              WrTake;
    logic              SlotMiss;
    logic [2:0]        FifoLevel;

    vram_write_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .NREQ(NR), .FDEPTH(FD)) dut (
        .MemClk(MemClk), .MemRstN(MemRstN), .ReqValid(ReqValid), .ReqAddr(ReqAddr),
        .ReqData(ReqData), .ReqAck(ReqAck), .SlotWrStrobe(SlotWrStrobe), .WrValid(WrValid),
        .WrAddr(WrAddr), .WrData(WrData), .WrTake(WrTake), .SlotMiss(SlotMiss),
        .FifoLevel(FifoLevel)
    );

    always #5 MemClk = ~MemClk;

    int n_cmp = 0;
    int n_fail = 0;

    // Stimulus state
    logic [NR-1:0] v_in;
    logic [AW-1:0] a_in [NR];
    logic [DW-1:0] d_in [NR];
    logic          s_in;

    // Reference model: queue of pending writes, RR start index, last acked requester
    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
    ent_t          mq[$];
    int            m_rr;
    int            m_ack;
    logic [NR-1:0] exp_ack;
    logic          exp_take, exp_miss;

    typedef struct {
        logic [NR-1:0] v; logic s; logic [NR-1:0] ack; int lvl; logic take; logic miss;
        logic [AW-1:0] head;
    } vec_t;
    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        ReqValid     = v_in;
        SlotWrStrobe = s_in;
        for (int i = 0; i < NR; i++) begin
            ReqAddr[i*AW +: AW] = a_in[i];
            ReqData[i*DW +: DW] = d_in[i];
        end
    endtask

    function automatic void m_reset();
        mq.delete();
        m_rr = 0;
        m_ack = -1;
        exp_ack = '0;
        exp_take = 1'b0;
        exp_miss = 1'b0;
    endfunction

    // One clock edge of the arbiter as described behaviourally.
    function automatic void m_edge();
        bit pop;
        bit push;
        int win;
        pop = s_in && (mq.size() > 0);
        win = -1;
        for (int k = 0; k < NR; k++) begin
            int j;
            j = (m_rr + k) % NR;
            if (win < 0 && v_in[j] && j != m_ack) win = j;
        end
        push = (win >= 0) && (mq.size() < FD || pop);
        exp_take = pop;
        exp_miss = s_in && (mq.size() == 0);
        exp_ack = '0;
        if (pop) void'(mq.pop_front());
        if (push) begin
            ent_t e;
            e.a = a_in[win];
            e.d = d_in[win];
            mq.push_back(e);
            exp_ack[win] = 1'b1;
            m_rr = (win + 1) % NR;
            m_ack = win;
        end else begin
            m_ack = -1;
        end
    endfunction

    task automatic compare_model();
        check("ack", 32'(ReqAck), 32'(exp_ack));
        check("take", 32'(WrTake), 32'(exp_take));
        check("miss", 32'(SlotMiss), 32'(exp_miss));
        check("level", 32'(FifoLevel), 32'(mq.size()));
        check("valid", 32'(WrValid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            check("head_addr", 32'(WrAddr), 32'(mq[0].a));
            check("head_data", 32'(WrData), 32'(mq[0].d));
        end
    endtask

    // Apply current inputs over one edge, then compare 1 time unit after it.
    task automatic step();
        drive();
        m_edge();
        @(posedge MemClk);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        MemRstN = 1'b0;
        v_in = '0;
        s_in = 1'b0;
        drive();
        m_reset();
        @(posedge MemClk);
        #1;
        MemRstN = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            a_in[i] = '0;
            d_in[i] = '0;
        end
        v_in = '0;
        s_in = 1'b0;
        MemRstN = 1'b0;
        drive();
        m_reset();
        #12;
        check("rst_ack", 32'(ReqAck), 0);
        check("rst_valid", 32'(WrValid), 0);
        check("rst_addr", 32'(WrAddr), 0);
        check("rst_data", 32'(WrData), 0);
        check("rst_take", 32'(WrTake), 0);
        check("rst_miss", 32'(SlotMiss), 0);
        check("rst_level", 32'(FifoLevel), 0);
        @(posedge MemClk);
        #1;
        MemRstN = 1'b1;

        // First write lands in the FIFO head
        a_in[0] = 19'h00123;
        d_in[0] = 8'hA5;
        v_in = 4'b0001;
        step();
        check("t1_ack", 32'(ReqAck), 32'h1);
        check("t1_valid", 32'(WrValid), 1);
        check("t1_addr", 32'(WrAddr), 32'h00123);
        check("t1_data", 32'(WrData), 32'hA5);
        check("t1_level", 32'(FifoLevel), 1);

        // Table: all four requesters hold valid, fill, stall, then drain
        do_reset();
        for (int i = 0; i < NR; i++) begin
            a_in[i] = AW'(32'h100 + i);
            d_in[i] = DW'(32'h10 + i);
        end
        tbl[0]  = '{4'hF, 1'b0, 4'b0001, 1, 1'b0, 1'b0, 19'h100};
        tbl[1]  = '{4'hF, 1'b0, 4'b0010, 2, 1'b0, 1'b0, 19'h100};
        tbl[2]  = '{4'hF, 1'b0, 4'b0100, 3, 1'b0, 1'b0, 19'h100};
        tbl[3]  = '{4'hF, 1'b0, 4'b1000, 4, 1'b0, 1'b0, 19'h100};
        tbl[4]  = '{4'hF, 1'b0, 4'b0000, 4, 1'b0, 1'b0, 19'h100};
        tbl[5]  = '{4'hF, 1'b0, 4'b0000, 4, 1'b0, 1'b0, 19'h100};
        tbl[6]  = '{4'hF, 1'b1, 4'b0001, 4, 1'b1, 1'b0, 19'h101};
        tbl[7]  = '{4'h0, 1'b1, 4'b0000, 3, 1'b1, 1'b0, 19'h102};
        tbl[8]  = '{4'h0, 1'b1, 4'b0000, 2, 1'b1, 1'b0, 19'h103};
        tbl[9]  = '{4'h0, 1'b1, 4'b0000, 1, 1'b1, 1'b0, 19'h100};
        tbl[10] = '{4'h0, 1'b1, 4'b0000, 0, 1'b1, 1'b0, 19'h000};
        tbl[11] = '{4'h0, 1'b1, 4'b0000, 0, 1'b0, 1'b1, 19'h000};
        tbl[12] = '{4'h0, 1'b0, 4'b0000, 0, 1'b0, 1'b0, 19'h000};
        for (int r = 0; r < 13; r++) begin
            v_in = tbl[r].v;
            s_in = tbl[r].s;
            step();
            check($sformatf("tbl%0d_ack", r), 32'(ReqAck), 32'(tbl[r].ack));
            check($sformatf("tbl%0d_level", r), 32'(FifoLevel), 32'(tbl[r].lvl));
            check($sformatf("tbl%0d_take", r), 32'(WrTake), 32'(tbl[r].take));
            check($sformatf("tbl%0d_miss", r), 32'(SlotMiss), 32'(tbl[r].miss));
            if (tbl[r].lvl > 0) check($sformatf("tbl%0d_head", r), 32'(WrAddr), 32'(tbl[r].head));
        end

        // Requesters 1 and 2 alternate after a prior grant to 1; strobe every 8 cycles
        do_reset();
        s_in = 1'b0;
        v_in = 4'b0010;
        step();
        check("rr_first", 32'(ReqAck), 32'b0010);
        v_in = 4'b0110;
        step();
        check("rr_g2", 32'(ReqAck), 32'b0100);
        step();
        check("rr_g1", 32'(ReqAck), 32'b0010);
        step();
        check("rr_g2b", 32'(ReqAck), 32'b0100);
        for (int c = 0; c < 32; c++) begin
            s_in = (c % 8 == 7);
            step();
        end
        v_in = '0;
        for (int c = 0; c < 8; c++) begin
            s_in = 1'b1;
            step();
        end

        // Push and pop on the same edge at level 2
        do_reset();
        v_in = 4'b0001;
        step();
        v_in = 4'b0010;
        step();
        check("pp_level2", 32'(FifoLevel), 2);
        v_in = 4'b0100;
        s_in = 1'b1;
        step();
        check("pp_level", 32'(FifoLevel), 2);
        check("pp_head", 32'(WrAddr), 32'h101);
        v_in = '0;
        step();
        check("pp_tail", 32'(WrAddr), 32'h102);
        check("pp_tail_d", 32'(WrData), 32'h12);
        s_in = 1'b0;

        // Asynchronous reset in the middle of a cycle with entries queued
        do_reset();
        v_in = 4'b0001;
        step();
        v_in = 4'b0010;
        step();
        v_in = 4'b1000;
        step();
        v_in = 4'b0000;
        step();
        check("ar_level3", 32'(FifoLevel), 3);
        v_in = 4'b1000;
        drive();
        #3;
        MemRstN = 1'b0;
        #1;
        check("ar_valid", 32'(WrValid), 0);
        check("ar_level", 32'(FifoLevel), 0);
        check("ar_ack", 32'(ReqAck), 0);
        m_reset();
        @(posedge MemClk);
        #1;
        MemRstN = 1'b1;
        v_in = 4'b0100;
        step();
        check("ar_grant2", 32'(ReqAck), 32'b0100);
        check("ar_head", 32'(WrAddr), 32'h102);

        // Random traffic; requesters hold their request until the model says it was acked
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!v_in[i]) begin
                    a_in[i] = AW'($urandom);
                    d_in[i] = DW'($urandom);
                    if ($urandom_range(2) == 0) v_in[i] = 1'b1;
                end else if (exp_ack[i]) begin
                    a_in[i] = AW'($urandom);
                    d_in[i] = DW'($urandom);
                    if ($urandom_range(1) == 0) v_in[i] = 1'b0;
                end
            end
            // Alternate phases of scarce and plentiful write slots
            if ((c / 200) % 2 == 0) s_in = ($urandom_range(3) == 0);
            else s_in = ($urandom_range(3) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
